sampling_index_gen: RTL

- Consumes the synchronized system time (57-bit, 20.48 MHz ticks) and its skip indication from the EtherCAT-locked time synchronizer.
- Derives a globally consistent sample index idx = floor(SYS_TIME / FREQ_DIV) mod CYCLE, which drives modulation and STM buffer reads.
- After each configuration update it recomputes idx by serial division, then tracks it incrementally, so all devices sharing SYS_TIME address the same sample.

---
 rtl/sampling_index_gen.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/sampling_index_gen.sv
// Sample index generator: idx = floor(SYS_TIME / FREQ_DIV) mod CYCLE, derived by
// two serial restoring divides after UPDATE, then caught up and tracked incrementally.
module sampling_index_gen #(
  parameter int TIME_W = 57,
  parameter int DIV_W  = 32,
  parameter int IDX_W  = 16,
  parameter int PEND_W = 9
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [TIME_W-1:0] SYS_TIME,
  input  logic              SKIP_ONE_ASSERT,
  input  logic              UPDATE,
  input  logic [DIV_W-1:0]  FREQ_DIV,
  input  logic [IDX_W-1:0]  CYCLE,
  output logic [IDX_W-1:0]  IDX,
  output logic              IDX_STEP,
  output logic              VALID,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(TIME_W);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV_T,
    ST_DIV_Q,
    ST_CATCHUP,
    ST_TRACK
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    cyc_q, cyc_d;
  logic [TIME_W-1:0]   quot_q, quot_d;
  logic [DIV_W-1:0]    r_q, r_d;
  logic [IDX_W-1:0]    crem_q, crem_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                idx_step_q, idx_step_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TIME_W-1:0]   time_prev_q, time_prev_d;

  logic                params_ok;
  logic                advance;
  logic [1:0]          tick_inc;
  logic                extra;
  logic [1:0]          step;
  logic [DIV_W:0]      step_sum;
  logic                wrap;
  logic [DIV_W-1:0]    r_wrap;
  logic [DIV_W-1:0]    r_adv;
  logic [IDX_W-1:0]    idx_adv;
  logic [DIV_W:0]      t_sh;
  logic                t_ge;
  logic [DIV_W-1:0]    t_diff;
  logic [IDX_W:0]      q_sh;
  logic                q_ge;
  logic [IDX_W-1:0]    q_diff;
  logic [IDX_W-1:0]    crem_next;
  logic                last_bit;
  logic [PEND_W-1:0]   pend_sum;
  logic [PEND_W-1:0]   pend_dec;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cyc_d       = cyc_q;
    quot_d      = quot_q;
    r_d         = r_q;
    crem_d      = crem_q;
    idx_d       = idx_q;
    idx_step_d  = 1'b0;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    time_prev_d = SYS_TIME;

    params_ok = (FREQ_DIV >= DIV_W'(4)) && (CYCLE != '0);
    advance   = (SYS_TIME != time_prev_q);
    tick_inc  = advance ? (SKIP_ONE_ASSERT ? 2'd2 : 2'd1) : 2'd0;
    extra     = (state_q == ST_CATCHUP) && (pend_q != '0);
    step      = tick_inc + {1'b0, extra};

    // Incremental step: R stays below FREQ_DIV, so at most one wrap per cycle.
    step_sum = {1'b0, r_q} + (DIV_W + 1)'(step);
    wrap     = step_sum >= {1'b0, div_q};
    r_wrap   = r_q + DIV_W'(step) - div_q;
    r_adv    = wrap ? r_wrap : step_sum[DIV_W-1:0];
    idx_adv  = idx_q;
    if (wrap) idx_adv = (idx_q == cyc_q - IDX_W'(1)) ? '0 : idx_q + IDX_W'(1);

    t_sh   = {r_q, quot_q[TIME_W-1]};
    t_ge   = t_sh >= {1'b0, div_q};
    t_diff = t_sh[DIV_W-1:0] - div_q;

    q_sh      = {crem_q, quot_q[TIME_W-1]};
    q_ge      = q_sh >= {1'b0, cyc_q};
    q_diff    = q_sh[IDX_W-1:0] - cyc_q;
    crem_next = q_ge ? q_diff : q_sh[IDX_W-1:0];

    last_bit = (cnt_q == CNT_W'(TIME_W - 1));
    pend_sum = pend_q + PEND_W'(tick_inc);
    pend_dec = pend_q - {{(PEND_W-1){1'b0}}, extra};

    case (state_q)
      ST_DIV_T: begin
        r_d    = t_ge ? t_diff : t_sh[DIV_W-1:0];
        quot_d = {quot_q[TIME_W-2:0], t_ge};
        cnt_d  = cnt_q + CNT_W'(1);
        pend_d = pend_sum;
        if (last_bit) begin
          cnt_d   = '0;
          crem_d  = '0;
          state_d = ST_DIV_Q;
        end
      end
      ST_DIV_Q: begin
        crem_d = crem_next;
        quot_d = {quot_q[TIME_W-2:0], 1'b0};
        cnt_d  = cnt_q + CNT_W'(1);
        pend_d = pend_sum;
        if (last_bit) begin
          cnt_d   = '0;
          idx_d   = crem_next;
          state_d = ST_CATCHUP;
        end
      end
      ST_CATCHUP: begin
        r_d    = r_adv;
        idx_d  = idx_adv;
        pend_d = pend_dec;
        if (pend_dec == '0) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        r_d        = r_adv;
        idx_d      = idx_adv;
        idx_step_d = (idx_adv != idx_q);
      end
      default: ;
    endcase

    // UPDATE from any state aborts whatever is running.
    if (UPDATE) begin
      idx_step_d = 1'b0;
      if (params_ok) begin
        div_d   = FREQ_DIV;
        cyc_d   = CYCLE;
        quot_d  = SYS_TIME;
        r_d     = '0;
        crem_d  = '0;
        pend_d  = '0;
        cnt_d   = '0;
        state_d = ST_DIV_T;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      cyc_q       <= '0;
      quot_q      <= '0;
      r_q         <= '0;
      crem_q      <= '0;
      idx_q       <= '0;
      idx_step_q  <= 1'b0;
      pend_q      <= '0;
      cnt_q       <= '0;
      time_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cyc_q       <= cyc_d;
      quot_q      <= quot_d;
      r_q         <= r_d;
      crem_q      <= crem_d;
      idx_q       <= idx_d;
      idx_step_q  <= idx_step_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      time_prev_q <= time_prev_d;
    end
  end

  assign IDX      = idx_q;
  assign IDX_STEP = idx_step_q;
  assign VALID    = (state_q == ST_TRACK);
  assign BUSY     = (state_q == ST_DIV_T) || (state_q == ST_DIV_Q) || (state_q == ST_CATCHUP);

endmodule
